// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage and the control unit.
// Contents: fetch FSM state enum, NOP instruction constant, 7-bit opcode
// constants, and the sequential next-PC helper.
// Macro FETCH_MISALIGN_TRAP_EN adds the FAULT state to the enum.
package fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [OPC_W-1:0] OP_IMM = 7'h13;
  localparam logic [OPC_W-1:0] OP     = 7'h33;
  localparam logic [OPC_W-1:0] BRANCH = 7'h63;
  localparam logic [OPC_W-1:0] SYSTEM = 7'h73;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1
  } state_t;
`endif

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] cur);
    return cur + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: holds the PC and the current instruction, issues
// one instruction-memory request per step and waits for the control unit to
// advance.
// Parameters: RESET_PC - word-aligned PC loaded on reset.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pc_enable         advance request from control (honoured only in HOLD)
//   pc_load, target   select branch target instead of pc+4
//   imem_req/addr     instruction memory request, address = pc
//   imem_ack/rdata    memory response
//   instr, opcode     registered instruction and its opcode field
//   pc                address of the current instruction
//   instr_valid       instr holds a fetched word (HOLD)
//   stall             high while fetching (and while faulted)
//   fault             only with FETCH_MISALIGN_TRAP_EN: sticky misaligned
//                     branch trap
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_enable,
  input  logic              pc_load,
  input  logic [XLEN-1:0]   target,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   instr,
  output logic [OPC_W-1:0]  opcode,
  output logic [XLEN-1:0]   pc,
  output logic              instr_valid,
  output logic              stall
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              fault
`endif
);

  state_t          state;
  logic [XLEN-1:0] load_pc;

  // With the trap enabled only aligned targets reach the PC; otherwise the
  // low bits are silently dropped.
`ifdef FETCH_MISALIGN_TRAP_EN
  assign load_pc = target;
`else
  assign load_pc = target & ~XLEN'(3);
`endif

  assign imem_addr = pc;
  assign opcode    = instr[OPC_W-1:0];

  // FSM, PC and instruction register; outputs registered alongside state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      imem_req    <= 1'b1;
      stall       <= 1'b1;
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault       <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            state       <= HOLD;
            imem_req    <= 1'b0;
            stall       <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (pc_enable) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pc_load && (target[1:0] != 2'b00)) begin
              state       <= FAULT;
              imem_req    <= 1'b0;
              stall       <= 1'b1;
              instr_valid <= 1'b0;
              fault       <= 1'b1;
            end else
`endif
            begin
              pc          <= pc_load ? load_pc : pc_plus4(pc);
              state       <= FETCH;
              imem_req    <= 1'b1;
              stall       <= 1'b1;
              instr_valid <= 1'b0;
            end
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        // Sticky until reset.
        FAULT: ;
`endif
        default: begin
          state       <= FETCH;
          imem_req    <= 1'b1;
          stall       <= 1'b1;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage (RESET_PC = 0x100).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_enable;
  logic        pc_load;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic        instr_valid;
  logic        stall;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_enable  (pc_enable),
    .pc_load    (pc_load),
    .target     (target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .pc         (pc),
    .instr_valid(instr_valid),
    .stall      (stall)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fault      (fault)
`endif
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic ack_with(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic step(input logic load, input logic [31:0] tgt);
    pc_enable = 1'b1;
    pc_load   = load;
    target    = tgt;
    tick();
    pc_enable = 1'b0;
    pc_load   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 32'h100 || imem_addr !== 32'h100) begin
      failures++; $display("FAIL reset_pc pc=%h addr=%h exp=00000100", pc, imem_addr);
    end
    checks++;
    if (imem_req !== 1'b1 || stall !== 1'b1 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL reset_ctl req=%b stall=%b valid=%b exp=1 1 0", imem_req, stall, instr_valid);
    end
    checks++;
    if (instr !== 32'h13 || opcode !== 7'h13) begin
      failures++; $display("FAIL reset_instr instr=%h opc=%h exp=00000013 13", instr, opcode);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (fault !== 1'b0) begin
      failures++; $display("FAIL reset_fault got=%b exp=0", fault);
    end
`endif
    // ack arrives on the third request cycle
    tick();
    checks++;
    if (imem_addr !== 32'h100 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL wait_hold addr=%h req=%b valid=%b exp=100 1 0", imem_addr, imem_req, instr_valid);
    end
    tick();
    ack_with(32'h00a2_8063);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00a2_8063 || opcode !== 7'h63) begin
      failures++; $display("FAIL first_fetch valid=%b instr=%h opc=%h exp=1 00a28063 63", instr_valid, instr, opcode);
    end
    checks++;
    if (imem_req !== 1'b0 || stall !== 1'b0 || pc !== 32'h100) begin
      failures++; $display("FAIL first_hold req=%b stall=%b pc=%h exp=0 0 100", imem_req, stall, pc);
    end
  endtask

  task automatic test_hold_ignores();
    // pc_load alone and a stray ack in HOLD change nothing
    pc_load    = 1'b1;
    target     = 32'h80;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick(2);
    pc_load  = 1'b0;
    imem_ack = 1'b0;
    checks++;
    if (pc !== 32'h100 || instr !== 32'h00a2_8063 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      failures++; $display("FAIL hold_stable pc=%h instr=%h valid=%b req=%b exp=100 00a28063 1 0", pc, instr, instr_valid, imem_req);
    end
  endtask

  task automatic test_seq_advance();
    step(1'b0, 32'h0);
    checks++;
    if (pc !== 32'h104 || imem_addr !== 32'h104 || imem_req !== 1'b1 || stall !== 1'b1 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL seq_adv pc=%h addr=%h req=%b stall=%b valid=%b exp=104 104 1 1 0", pc, imem_addr, imem_req, stall, instr_valid);
    end
    checks++;
    if (instr !== 32'h00a2_8063) begin
      failures++; $display("FAIL seq_instr_held got=%h exp=00a28063", instr);
    end
    ack_with(32'h0000_0033);
    checks++;
    if (instr !== 32'h33 || opcode !== 7'h33 || instr_valid !== 1'b1) begin
      failures++; $display("FAIL seq_fetch instr=%h opc=%h valid=%b exp=00000033 33 1", instr, opcode, instr_valid);
    end
  endtask

  task automatic test_branch();
    step(1'b1, 32'h40);
    checks++;
    if (pc !== 32'h40 || imem_req !== 1'b1) begin
      failures++; $display("FAIL branch_aligned pc=%h req=%b exp=40 1", pc, imem_req);
    end
    ack_with(32'h0000_0013);
    step(1'b1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || stall !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h40) begin
      failures++; $display("FAIL branch_trap fault=%b req=%b stall=%b valid=%b pc=%h exp=1 0 1 0 40", fault, imem_req, stall, instr_valid, pc);
    end
    imem_ack = 1'b1;
    step(1'b0, 32'h0);
    tick(2);
    imem_ack = 1'b0;
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h40) begin
      failures++; $display("FAIL fault_sticky fault=%b req=%b pc=%h exp=1 0 40", fault, imem_req, pc);
    end
    do_reset();
    checks++;
    if (fault !== 1'b0 || pc !== 32'h100 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL fault_reset fault=%b pc=%h req=%b valid=%b exp=0 100 1 0", fault, pc, imem_req, instr_valid);
    end
`else
    checks++;
    if (pc !== 32'h40 || imem_req !== 1'b1 || stall !== 1'b1) begin
      failures++; $display("FAIL branch_misalign pc=%h req=%b stall=%b exp=40 1 1", pc, imem_req, stall);
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    ack_with(32'h13);
    step(1'b1, 32'hFFFF_FFFC);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_setup pc=%h exp=fffffffc", pc);
    end
    ack_with(32'h13);
    step(1'b0, 32'h0);
    checks++;
    if (pc !== 32'h0 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL wrap pc=%h addr=%h exp=00000000", pc, imem_addr);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    reset      = 1'b1;
    tick();
    reset    = 1'b0;
    imem_ack = 1'b0;
    checks++;
    if (instr !== 32'h13 || instr_valid !== 1'b0 || pc !== 32'h100 || imem_req !== 1'b1 || stall !== 1'b1) begin
      failures++; $display("FAIL reset_vs_ack instr=%h valid=%b pc=%h req=%b stall=%b exp=13 0 100 1 1", instr, instr_valid, pc, imem_req, stall);
    end
    ack_with(32'h33);
    reset = 1'b1;
    step(1'b0, 32'h0);
    reset = 1'b0;
    checks++;
    if (pc !== 32'h100 || instr !== 32'h13 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL reset_vs_enable pc=%h instr=%h req=%b valid=%b exp=100 13 1 0", pc, instr, imem_req, instr_valid);
    end
  endtask

  task automatic test_enable_during_fetch();
    do_reset();
    pc_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pc !== 32'h100 || imem_req !== 1'b1) begin
        failures++; $display("FAIL fetch_ignore_en cyc=%0d pc=%h req=%b exp=100 1", i, pc, imem_req);
      end
    end
    ack_with(32'h0000_0073);
    checks++;
    if (pc !== 32'h100 || instr_valid !== 1'b1 || opcode !== 7'h73) begin
      failures++; $display("FAIL en_reach_hold pc=%h valid=%b opc=%h exp=100 1 73", pc, instr_valid, opcode);
    end
    tick();
    checks++;
    if (pc !== 32'h104 || imem_req !== 1'b1) begin
      failures++; $display("FAIL en_one_adv pc=%h req=%b exp=104 1", pc, imem_req);
    end
    tick(3);
    checks++;
    if (pc !== 32'h104 || imem_req !== 1'b1) begin
      failures++; $display("FAIL en_no_double pc=%h req=%b exp=104 1", pc, imem_req);
    end
    pc_enable = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    pc_enable  = 1'b0;
    pc_load    = 1'b0;
    target     = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    tick();
    test_reset();
    test_hold_ignores();
    test_seq_advance();
    test_branch();
    test_wrap();
    test_reset_priority();
    test_enable_during_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
